stopwatch_ctrl: RTL and testbench
=================================

# stopwatch_ctrl

Run/pause/clear controller and BCD time accumulator sitting directly downstream of the 24-bit free-running tick counter. It drives that counter's enable and consumes its terminal-count pulse as a timebase tick. Each tick advances an MM:SS BCD count with wrap at 59:59. Four BCD digits and status flags go to the seven-segment display stage.

## Interface
- SYNC_STAGES, 2, flip-flop depth of the button synchronizers (minimum 2)
- clk  in  1  system clock; all state on rising edge
- reset  in  1  asynchronous, active-low reset
- tick  in  1  timebase pulse from counter TC; one cycle wide
- btn_start_stop  in  1  asynchronous level; rising edge toggles run/pause
- btn_clear  in  1  asynchronous level; rising edge zeroes count
- btn_lap  in  1  asynchronous level; lap freeze toggle (active only with STOPWATCH_LAP_EN)
- cnt_en  out  1  enable to upstream tick counter; high only in RUN
- sec_ones, sec_tens, min_ones, min_tens  out  4 each  displayed BCD digits
- running  out  1  high in RUN
- wrap  out  1  one-cycle pulse when count rolls 59:59 -> 00:00
- lap_active  out  1  display frozen (always 0 without STOPWATCH_LAP_EN)

## Operation
- Buttons: SYNC_STAGES-flop synchronizer, then a registered rising-edge detector. Each produces a one-cycle internal pulse (ss_p, clr_p, lap_p).
- FSM states: IDLE, RUN, PAUSE.
  - IDLE: ss_p -> RUN.
  - RUN: ss_p -> PAUSE; clr_p -> IDLE.
  - PAUSE: ss_p -> RUN; clr_p -> IDLE.
- Priority: clr_p over ss_p in the same cycle. clr_p in IDLE re-zeroes and stays in IDLE.
- Entering IDLE zeroes all digits and clears lap_active.
- Count advances only when tick=1 and the current registered state is RUN. A tick arriving in the same cycle as ss_p while in RUN is counted.
- Digit rules, each digit saturating-free modulo:
  - sec_ones 0-9; carry into sec_tens.
  - sec_tens 0-5; carry into min_ones.
  - min_ones 0-9; carry into min_tens.
  - min_tens 0-5.
- At 59:59, a tick gives 00:00 and asserts wrap for one cycle; state stays RUN.
- Digits never hold a non-BCD value. Arithmetic is 4-bit per digit; no binary-to-BCD conversion.
- cnt_en = (state == RUN), decoded combinationally from the state register.
- Reset values: state IDLE, all digits 0, cnt_en 0, running 0, wrap 0, lap_active 0, synchronizer and edge-detect flops 0.

## Timing
- Tick latency: tick sampled at edge N; updated digits visible after edge N.
- Button latency: with SYNC_STAGES=2, an input rise before edge N gives the state change after edge N+2.
- cnt_en falls in the same cycle as running, so the counter stops on the next edge. At most one in-flight TC can arrive after a pause, and it is ignored.
- Reset mid-count: all outputs go to reset values immediately (asynchronous). Release is used synchronously on the next clk edge.
- Held buttons produce exactly one pulse; re-arming requires the synchronized input to return to 0.

## Configuration
- STOPWATCH_LAP_EN defined:
  - lap_p in RUN toggles lap_active.
  - While lap_active=1, the output digits hold the value latched on the set edge; the internal count keeps advancing.
  - Clearing lap_active shows the live count on the next cycle.
  - lap_p in IDLE or PAUSE is ignored.
- Not defined: btn_lap is unused, lap_active is tied 0, and the outputs always show the live count.

## Structure
- Package stopwatch_pkg holds:
  - state enum type: IDLE, RUN, PAUSE
  - constants DIGIT_MAX_ONES=9, DIGIT_MAX_TENS=5
  - reset digit value 4'd0
- Sub-module bcd_digit: parameter MAX; inputs clk, reset, clr, inc; outputs q[3:0] and carry.
  - carry = inc && q==MAX.
  - Instantiate four in a carry chain.
- Synchronizer/edge-detect stays inline in a generate loop.

## Test plan
- Reset then start: release reset, pulse btn_start_stop, send 10 ticks -> running=1, cnt_en=1, display 00:10.
- Wrap: preload by ticking to 59:58, then 2 ticks -> 59:59, then 00:00 with a single-cycle wrap.
- Pause/resume: in RUN at 00:05, press start_stop coincident with a tick -> 00:06, PAUSE. Then 3 ticks -> still 00:06, cnt_en=0.
- Clear priority: in PAUSE at 01:23, press clear and start_stop in the same cycle -> IDLE, 00:00, running=0.
- Async reset mid-run: at 00:42, assert reset between edges -> digits 0 and cnt_en 0 before the next edge; stays IDLE after release.
- Lap (STOPWATCH_LAP_EN): at 00:07 press lap, send 5 ticks -> display 00:07, lap_active=1. Press lap -> display 00:12.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch controller.
// Holds the FSM state encoding, per-digit modulo limits and the digit reset value.
// No logic; imported by stopwatch_ctrl and bcd_digit.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam logic [3:0] DIGIT_MAX_ONES = 4'd9;
    localparam logic [3:0] DIGIT_MAX_TENS = 4'd5;
    localparam logic [3:0] DIGIT_RST      = 4'd0;

endpackage

// File: rtl/stopwatch_bcd_digit.sv
// Single BCD digit counter, modulo MAX+1, with synchronous clear.
// Latency: q updates on the clock edge where inc/clr is sampled; carry is combinational.
// Ports: clk, reset (async active-low), clr, inc -> q[3:0], carry (= inc && q==MAX).
module bcd_digit
    import stopwatch_pkg::*;
#(
    parameter logic [3:0] MAX = DIGIT_MAX_ONES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       inc,
    output logic [3:0] q,
    output logic       carry
);

    logic [3:0] q_q;
    logic [3:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = DIGIT_RST;
        end else if (inc) begin
            q_d = (q_q == MAX) ? DIGIT_RST : q_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_q <= DIGIT_RST;
        end else begin
            q_q <= q_d;
        end
    end

    assign q     = q_q;
    assign carry = inc && (q_q == MAX);

endmodule

// File: rtl/stopwatch_ctrl.sv
// Run/pause/clear stopwatch controller with an MM:SS BCD accumulator (wraps at 59:59).
// Latency: tick -> digits one edge; button rise -> state change after SYNC_STAGES+1 edges.
// Ports: clk, reset (async active-low), tick, btn_* in; cnt_en, BCD digits, running, wrap, lap_active out.
// Optional lap-freeze display enabled by defining STOPWATCH_LAP_EN.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int SYNC_STAGES = 2   // must be >= 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       btn_start_stop,
    input  logic       btn_clear,
    input  logic       btn_lap,
    output logic       cnt_en,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic       running,
    output logic       wrap,
    output logic       lap_active
);

`ifdef STOPWATCH_LAP_EN
    localparam int NBTN = 3;
    logic [NBTN-1:0] btn_in;
    assign btn_in = {btn_lap, btn_clear, btn_start_stop};
`else
    localparam int NBTN = 2;
    logic [NBTN-1:0] btn_in;
    logic            btn_lap_unused;
    assign btn_in         = {btn_clear, btn_start_stop};
    assign btn_lap_unused = btn_lap;
`endif

    // Synchronizer chain plus a delayed copy of its last stage; the pulse is
    // the first cycle the synchronized level reads 1, so a held button fires once.
    logic [NBTN-1:0] btn_pulse;

    for (genvar b = 0; b < NBTN; b++) begin : g_btn
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   edge_q;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                sync_q <= '0;
                edge_q <= 1'b0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in[b]};
                edge_q <= sync_q[SYNC_STAGES-1];
            end
        end

        assign btn_pulse[b] = sync_q[SYNC_STAGES-1] & ~edge_q;
    end

    logic ss_p;
    logic clr_p;
    assign ss_p  = btn_pulse[0];
    assign clr_p = btn_pulse[1];

    state_t state_q;
    logic   running_q;
    logic   wrap_q;

    // Counting is gated by the registered state, so a tick coincident with the
    // pause press is still counted and a late TC after pause is dropped.
    logic inc;
    assign inc = tick && (state_q == RUN);

    logic [3:0] so_q, st_q, mo_q, mt_q;
    logic       so_c, st_c, mo_c, mt_c;

    bcd_digit #(.MAX(DIGIT_MAX_ONES)) u_sec_ones (
        .clk(clk), .reset(reset), .clr(clr_p), .inc(inc),  .q(so_q), .carry(so_c));
    bcd_digit #(.MAX(DIGIT_MAX_TENS)) u_sec_tens (
        .clk(clk), .reset(reset), .clr(clr_p), .inc(so_c), .q(st_q), .carry(st_c));
    bcd_digit #(.MAX(DIGIT_MAX_ONES)) u_min_ones (
        .clk(clk), .reset(reset), .clr(clr_p), .inc(st_c), .q(mo_q), .carry(mo_c));
    bcd_digit #(.MAX(DIGIT_MAX_TENS)) u_min_tens (
        .clk(clk), .reset(reset), .clr(clr_p), .inc(mo_c), .q(mt_q), .carry(mt_c));

    // running_q is loaded with the same next-state decision as state_q, so it
    // always equals (state_q == RUN) and falls together with cnt_en.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            running_q <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            wrap_q <= mt_c && !clr_p;
            if (clr_p) begin
                state_q   <= IDLE;
                running_q <= 1'b0;
            end else if (ss_p) begin
                state_q   <= (state_q == RUN) ? PAUSE : RUN;
                running_q <= (state_q != RUN);
            end
        end
    end

    assign cnt_en  = (state_q == RUN);
    assign running = running_q;
    assign wrap    = wrap_q;

    logic [15:0] live_dig;
    assign live_dig = {mt_q, mo_q, st_q, so_q};

`ifdef STOPWATCH_LAP_EN
    logic        lap_p;
    logic        lap_q;
    logic [15:0] lap_dig_q;
    assign lap_p = btn_pulse[2];

    // Snapshot is taken on the setting edge; the live chain keeps counting.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lap_q     <= 1'b0;
            lap_dig_q <= '0;
        end else if (clr_p) begin
            lap_q <= 1'b0;
        end else if (lap_p && (state_q == RUN)) begin
            lap_q <= !lap_q;
            if (!lap_q) begin
                lap_dig_q <= live_dig;
            end
        end
    end

    assign lap_active                             = lap_q;
    assign {min_tens, min_ones, sec_tens, sec_ones} = lap_q ? lap_dig_q : live_dig;
`else
    assign lap_active                             = 1'b0;
    assign {min_tens, min_ones, sec_tens, sec_ones} = live_dig;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: table of button/tick vectors plus
// hand-written sequences for coincident press, wrap, held button, lap and async reset.
// Expected values are queued at drive time and popped when outputs are sampled.
module tb_stopwatch_ctrl;

`ifdef STOPWATCH_LAP_EN
    localparam bit LAP = 1'b1;
`else
    localparam bit LAP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tick = 1'b0;
    logic       btn_start_stop = 1'b0;
    logic       btn_clear = 1'b0;
    logic       btn_lap = 1'b0;
    logic       cnt_en, running, wrap, lap_active;
    logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
    logic [15:0] disp;

    stopwatch_ctrl #(.SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .tick(tick),
        .btn_start_stop(btn_start_stop), .btn_clear(btn_clear), .btn_lap(btn_lap),
        .cnt_en(cnt_en),
        .sec_ones(sec_ones), .sec_tens(sec_tens), .min_ones(min_ones), .min_tens(min_tens),
        .running(running), .wrap(wrap), .lap_active(lap_active)
    );

    always #5 clk = ~clk;

    assign disp = {min_tens, min_ones, sec_tens, sec_ones};

    typedef struct {
        logic [15:0] t;
        logic        run;
        logic        wrp;
        logic        lap;
    } exp_t;

    typedef struct {
        bit          ss;
        bit          clr;
        int          n;
        logic [15:0] t;
        bit          run;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[11];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic push(input logic [15:0] t, input logic run, input logic wrp, input logic lap);
        exp_t e;
        e.t = t; e.run = run; e.wrp = wrp; e.lap = lap;
        sb.push_back(e);
    endtask

    task automatic compare(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty, got output %0h expected queued entry", name, disp);
        end else begin
            e = sb.pop_front();
            chk({name, "_time"}, disp, e.t);
            chk({name, "_running"}, {15'd0, running}, {15'd0, e.run});
            chk({name, "_cnt_en"}, {15'd0, cnt_en}, {15'd0, e.run});
            chk({name, "_wrap"}, {15'd0, wrap}, {15'd0, e.wrp});
            chk({name, "_lap"}, {15'd0, lap_active}, {15'd0, e.lap});
        end
    endtask

    // Raise the selected buttons long enough for the 2-flop sync plus edge
    // detect to act, then release and allow the detector to re-arm.
    task automatic press(input bit ss, input bit clr, input bit lap);
        @(negedge clk);
        btn_start_stop = ss; btn_clear = clr; btn_lap = lap;
        repeat (3) @(negedge clk);
        btn_start_stop = 1'b0; btn_clear = 1'b0; btn_lap = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // n consecutive one-cycle-spaced ticks; returns at the negedge right after the last one.
    task automatic ticks(input int n);
        if (n > 0) begin
            @(negedge clk);
            tick = 1'b1;
            repeat (n) @(negedge clk);
            tick = 1'b0;
        end
    endtask

    initial begin
        vecs[0]  = '{ss:0, clr:0, n:0,  t:16'h0000, run:0};
        vecs[1]  = '{ss:1, clr:0, n:10, t:16'h0010, run:1};
        vecs[2]  = '{ss:0, clr:0, n:5,  t:16'h0015, run:1};
        vecs[3]  = '{ss:1, clr:0, n:3,  t:16'h0015, run:0};
        vecs[4]  = '{ss:1, clr:0, n:50, t:16'h0105, run:1};
        vecs[5]  = '{ss:0, clr:1, n:0,  t:16'h0000, run:0};
        vecs[6]  = '{ss:0, clr:0, n:4,  t:16'h0000, run:0};
        vecs[7]  = '{ss:0, clr:1, n:0,  t:16'h0000, run:0};
        vecs[8]  = '{ss:1, clr:0, n:83, t:16'h0123, run:1};
        vecs[9]  = '{ss:1, clr:0, n:0,  t:16'h0123, run:0};
        vecs[10] = '{ss:1, clr:1, n:0,  t:16'h0000, run:0};

        // Reset state, while reset is still asserted.
        repeat (3) @(negedge clk);
        push(16'h0000, 1'b0, 1'b0, 1'b0);
        compare("reset");
        reset = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            if (vecs[i].ss || vecs[i].clr) press(vecs[i].ss, vecs[i].clr, 1'b0);
            ticks(vecs[i].n);
            push(vecs[i].t, vecs[i].run, 1'b0, 1'b0);
            compare($sformatf("vec%0d", i));
        end

        // Pause press coincident with a tick: the tick is still counted.
        press(1'b1, 1'b0, 1'b0);
        ticks(5);
        push(16'h0005, 1'b1, 1'b0, 1'b0);
        compare("pre_pause");
        @(negedge clk); btn_start_stop = 1'b1;
        @(negedge clk);
        @(negedge clk); tick = 1'b1;
        @(negedge clk); tick = 1'b0; btn_start_stop = 1'b0;
        push(16'h0006, 1'b0, 1'b0, 1'b0);
        compare("coincident_pause");
        repeat (4) @(negedge clk);
        ticks(3);
        push(16'h0006, 1'b0, 1'b0, 1'b0);
        compare("paused_ticks");

        // Wrap at 59:59.
        press(1'b0, 1'b1, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        ticks(3598);
        push(16'h5958, 1'b1, 1'b0, 1'b0);
        compare("preload");
        ticks(1);
        push(16'h5959, 1'b1, 1'b0, 1'b0);
        compare("at_5959");
        ticks(1);
        push(16'h0000, 1'b1, 1'b1, 1'b0);
        compare("wrap_pulse");
        @(negedge clk);
        push(16'h0000, 1'b1, 1'b0, 1'b0);
        compare("wrap_end");

        // A held start/stop button toggles exactly once.
        @(negedge clk); btn_start_stop = 1'b1;
        repeat (12) @(negedge clk);
        push(16'h0000, 1'b0, 1'b0, 1'b0);
        compare("held_press");
        btn_start_stop = 1'b0;
        repeat (4) @(negedge clk);
        push(16'h0000, 1'b0, 1'b0, 1'b0);
        compare("held_release");

        // Lap freeze (a no-op unless the lap feature is built in).
        press(1'b0, 1'b1, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        ticks(7);
        push(16'h0007, 1'b1, 1'b0, 1'b0);
        compare("lap_pre");
        press(1'b0, 1'b0, 1'b1);
        push(16'h0007, 1'b1, 1'b0, LAP);
        compare("lap_set");
        ticks(5);
        push(LAP ? 16'h0007 : 16'h0012, 1'b1, 1'b0, LAP);
        compare("lap_frozen");
        press(1'b0, 1'b0, 1'b1);
        push(16'h0012, 1'b1, 1'b0, 1'b0);
        compare("lap_release");
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b0, 1'b1);
        push(16'h0012, 1'b0, 1'b0, 1'b0);
        compare("lap_in_pause");

        // Asynchronous reset mid-run.
        press(1'b0, 1'b1, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        ticks(42);
        push(16'h0042, 1'b1, 1'b0, 1'b0);
        compare("pre_reset");
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        push(16'h0000, 1'b0, 1'b0, 1'b0);
        compare("async_reset");
        @(negedge clk); reset = 1'b1;
        ticks(3);
        repeat (2) @(negedge clk);
        push(16'h0000, 1'b0, 1'b0, 1'b0);
        compare("post_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
